// File: rtl/imem_loadable_pkg.sv
// Shared types and defaults for the loadable LEGv8 instruction memory.
package imem_pkg;

  typedef enum logic [1:0] {IMEM_EMPTY, IMEM_LOAD, IMEM_RUN} imem_state_t;

  localparam int IMEM_N_DEFAULT     = 32;
  localparam int IMEM_DEPTH_DEFAULT = 64;

endpackage

// File: rtl/imem_loadable_if.sv
// Program-load stream and fetch read port of the loadable instruction memory.
interface imem_loadable_if #(
  parameter int N     = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
);

  logic          ld_start;
  logic          ld_valid;
  logic          ld_last;
  logic [N-1:0]  ld_data;
  logic          ld_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [N-1:0]  rd_data;
  logic          rd_err;
  logic [AW:0]   prog_len;

  modport master (
    output ld_start, ld_valid, ld_last, ld_data, rd_en, rd_addr,
    input  ld_ready, rd_valid, rd_data, rd_err, prog_len
  );

  modport slave (
    input  ld_start, ld_valid, ld_last, ld_data, rd_en, rd_addr,
    output ld_ready, rd_valid, rd_data, rd_err, prog_len
  );

endinterface

// File: rtl/imem_loadable_ram.sv
// Single-write, single-registered-read word array; contents are never reset.
module imem_ram #(
  parameter int N     = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [N-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [N-1:0]  rdata_o
);

  logic [N-1:0] mem_q [DEPTH];
  logic [N-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loadable.sv
// Run-time loadable instruction memory: load FSM, program length tracking and
// a one-cycle read whose data is forced to 0 whenever the address is not in the program.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int N     = IMEM_N_DEFAULT,
  parameter int DEPTH = IMEM_DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  imem_loadable_if.slave bus
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  imem_state_t   state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic          wr_en;
  logic          rd_hit;
  logic          rd_valid_q, rd_err_q;
  logic [N-1:0]  ram_rdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IMEM_EMPTY;
      wptr_q     <= '0;
      prog_len_q <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      prog_len_q <= prog_len_d;
    end
  end

  // A start inside LOAD restarts the session and drops any word offered with it.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    prog_len_d = prog_len_q;
    wr_en      = 1'b0;
    case (state_q)
      IMEM_LOAD: begin
        if (bus.ld_start) begin
          wptr_d     = '0;
          prog_len_d = '0;
        end else if (bus.ld_valid) begin
          wr_en = 1'b1;
          if (bus.ld_last || (wptr_q == LAST_ADDR)) begin
            state_d    = IMEM_RUN;
            prog_len_d = {1'b0, wptr_q} + (AW+1)'(1);
          end else begin
            wptr_d = wptr_q + AW'(1);
          end
        end
      end
      IMEM_EMPTY, IMEM_RUN: begin
        if (bus.ld_start) begin
          state_d    = IMEM_LOAD;
          wptr_d     = '0;
          prog_len_d = '0;
        end
      end
      default: state_d = IMEM_EMPTY;
    endcase
  end

  // Judged on pre-edge state, so a read alongside ld_start still sees the old program.
  assign rd_hit = (state_q == IMEM_RUN) && ({1'b0, bus.rd_addr} < prog_len_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      rd_err_q   <= bus.rd_en && !rd_hit;
    end
  end

  imem_ram #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (bus.ld_data),
    .re_i    (bus.rd_en && rd_hit),
    .raddr_i (bus.rd_addr),
    .rdata_o (ram_rdata)
  );

  assign bus.ld_ready = (state_q == IMEM_LOAD);
  assign bus.prog_len = prog_len_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.rd_data  = (rd_valid_q && !rd_err_q) ? ram_rdata : '0;

endmodule
